// File: rtl/bus_arb_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding,
// active-low handshake levels and elaboration helpers.
package bus_arb_rr_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DEF_TMO_CYC = 255;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arb_rr_rr_pick.sv
// Combinational round-robin picker: first active request strictly after
// 'last' (with wrap), ignoring masters in the exclude mask.
module rr_pick
    import bus_arb_rr_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    input  logic [N-1:0]     excl_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

    // Modulo-N add; both operands are always below N so one subtract suffices.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_EXT) s = s - N_EXT;
        return s[IDX_W-1:0];
    endfunction

    logic [N-1:0]     masked;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] enc;

    assign masked = req_i & ~excl_i;
    assign start  = wrap_add(last_i, IDX_W'(1));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = masked[wrap_add(start, IDX_W'(gi))];
        end
    endgenerate

    always_comb begin
        enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) enc = IDX_W'(i);
        end
    end

    assign valid_o = |rot;
    assign idx_o   = wrap_add(start, enc);

endmodule

// File: rtl/bus_arb_rr.sv
// Round-robin bus arbiter with active-low request/grant, hold-until-release
// ownership and a per-grant hold timeout.
module bus_arb_rr
    import bus_arb_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = clog2_f(NUM_MASTERS),
    parameter int TMO_W       = 8,
    parameter int TMO_CYC     = DEF_TMO_CYC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_req_n,
    output logic [NUM_MASTERS-1:0] m_grnt_n,
    output logic [IDX_W-1:0]       owner,
    output logic                   bus_busy,
    output logic                   tmo_evt
);

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grnt_n_q, grnt_n_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   busy_q, busy_d;
    logic                   tmo_evt_q, tmo_evt_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] excl;
    logic                   owner_req;
    logic                   tmo_hit;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   do_grant;

    assign req       = ~m_req_n;
    assign owner_req = req[owner_q];
    assign tmo_hit   = (TMO_CYC != 0) && (tmo_cnt_q == TMO_LAST);

    // A releasing owner is kept out of the handover search.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_excl
            assign excl[gi] = (state_q == ARB_GRANT) && !owner_req &&
                              (owner_q == IDX_W'(gi));
        end
    endgenerate

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .excl_i  (excl),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        grnt_n_d  = grnt_n_q;
        owner_d   = owner_q;
        last_d    = last_q;
        tmo_cnt_d = tmo_cnt_q;
        busy_d    = busy_q;
        tmo_evt_d = 1'b0;
        do_grant  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                do_grant = pick_valid;
            end
            ARB_GRANT: begin
                if (!owner_req) begin
                    if (pick_valid) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d  = ARB_IDLE;
                        grnt_n_d = {NUM_MASTERS{DISABLE_}};
                        busy_d   = 1'b0;
                    end
                end else if (tmo_hit) begin
                    // last_q equals the owner, so it ranks lowest in this pick.
                    do_grant  = 1'b1;
                    tmo_evt_d = 1'b1;
                end else if (tmo_cnt_q != {TMO_W{1'b1}}) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: ;
        endcase

        if (do_grant) begin
            state_d            = ARB_GRANT;
            grnt_n_d           = {NUM_MASTERS{DISABLE_}};
            grnt_n_d[pick_idx] = ENABLE_;
            owner_d            = pick_idx;
            last_d             = pick_idx;
            tmo_cnt_d          = '0;
            busy_d             = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            grnt_n_q  <= {NUM_MASTERS{DISABLE_}};
            owner_q   <= '0;
            last_q    <= LAST_RST;
            tmo_cnt_q <= '0;
            busy_q    <= 1'b0;
            tmo_evt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grnt_n_q  <= grnt_n_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            tmo_cnt_q <= tmo_cnt_d;
            busy_q    <= busy_d;
            tmo_evt_q <= tmo_evt_d;
        end
    end

    assign m_grnt_n = grnt_n_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;
    assign tmo_evt  = tmo_evt_q;

endmodule
